// File: rtl/pipe_shifter_if.sv
// Handshake bundle for pipe_shifter: the operation side (in_*, operand and
// shift controls) and the result side (out_*). The shifter takes the slave
// modport; the producer/consumer environment takes the master modport.
interface pipe_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int L = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic [L-1:0]     shamt;
    logic             dir;
    logic             aorl;
    logic             rot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;

    modport master (
        output in_valid, in, shamt, dir, aorl, rot, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, shamt, dir, aorl, rot, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/pipe_shifter.sv
// Fully pipelined barrel shifter. Stage k applies a shift of 2^k when bit k
// of the shift amount is set, so a WIDTH-bit operand takes $clog2(WIDTH)
// cycles. Per-stage valid/ready flow control collapses bubbles, so a stalled
// pipe fills completely before in_ready drops.
// Optional feature macro: SHIFTER_ROTATE_EN (honour the rot input). When it
// is undefined, rot is ignored and no rotate muxing is built.
module pipe_shifter #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    pipe_shifter_if.slave bus
);
    localparam int L = $clog2(WIDTH);

    // Everything a stage carries alongside its valid bit.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [L-1:0]     shamt;
        logic             dir;
        logic             aorl;
`ifdef SHIFTER_ROTATE_EN
        logic             rot;
`endif
    } stage_t;

    logic [L-1:0] valid;
    logic [L-1:0] adv;
    logic [L-1:0] src_valid;
    stage_t       stg [L];
    stage_t       src [L];
    stage_t       nxt [L];

    // One shift level: move d by n positions according to the mode bits.
    // In arithmetic mode the MSB of d is still the operand's sign bit,
    // because every earlier level preserved it.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input int               n,
        input stage_t           ctl
    );
        logic [WIDTH-1:0] r;
`ifdef SHIFTER_ROTATE_EN
        if (ctl.rot) begin
            if (ctl.dir) r = (d << n) | (d >> (WIDTH - n));
            else         r = (d >> n) | (d << (WIDTH - n));
        end else
`endif
        if (ctl.dir)       r = d << n;
        else if (ctl.aorl) r = $unsigned($signed(d) >>> n);
        else               r = d >> n;
        return r;
    endfunction

    // Stage inputs: stage 0 reads the bus, every later stage its predecessor.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here by a full default first) so no latch is inferred.
        src_valid    = '0;
        src[0]       = '0;
        src_valid[0] = bus.in_valid;
        src[0].data  = bus.in;
        src[0].shamt = bus.shamt;
        src[0].dir   = bus.dir;
        src[0].aorl  = bus.aorl;
`ifdef SHIFTER_ROTATE_EN
        src[0].rot   = bus.rot;
`endif
        for (int k = 1; k < L; k++) begin
            src[k]       = stg[k-1];
            src_valid[k] = valid[k-1];
        end
    end

    // Next contents of each stage: conditionally shift by this level's 2^k.
    always_comb begin
        for (int k = 0; k < L; k++) begin
            nxt[k] = src[k];
            if (src[k].shamt[k]) nxt[k].data = shift_by(src[k].data, 1 << k, src[k]);
        end
    end

    // Advance chain: a stage may load when it is empty or anything
    // downstream of it (including the consumer) makes room this cycle.
    always_comb begin
        logic room;
        room = bus.out_ready;
        adv  = '0;
        for (int k = L - 1; k >= 0; k--) begin
            room   = room || !valid[k];
            adv[k] = room;
        end
    end

    // Pipeline registers: move each stage forward when its advance is granted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every stage reads the
        // pre-edge value of its neighbour, giving a true register chain.
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                valid[k] <= 1'b0;
                // NOTE: the data registers are reset too, because the result
                // port must read zero right after reset, not stale contents.
                stg[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                if (adv[k]) begin
                    valid[k] <= src_valid[k];
                    if (src_valid[k]) stg[k] <= nxt[k];
                end
            end
        end
    end

    assign bus.in_ready  = adv[0] && !rst;
    assign bus.out_valid = valid[L-1];
    assign bus.out       = stg[L-1].data;
endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter (WIDTH = 32). A bit-index reference
// model predicts every result; a queue of expected results tracks the
// in-flight operations and also predicts in_ready from the occupancy.
// Honours SHIFTER_ROTATE_EN the same way the design does.
module tb_pipe_shifter;
    localparam int W = 32;
    localparam int L = $clog2(W);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_shifter_if #(.WIDTH(W)) bus ();
    pipe_shifter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    int accepted = 0;
    int emitted = 0;
    logic [W-1:0] q[$];
    logic hold_pending = 1'b0;
    logic [W-1:0] held = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result predicted bit by bit: out[i] takes operand bit i-s (left) or
    // i+s (right); out-of-range positions take the fill, or wrap on rotate.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input int s,
                                           input logic d, input logic ar, input logic r);
        logic [W-1:0] res;
        logic fill;
        logic use_rot;
        int src;
`ifdef SHIFTER_ROTATE_EN
        use_rot = r;
`else
        use_rot = 1'b0 & r;
`endif
        fill = (!d && ar && !use_rot) ? a[W-1] : 1'b0;
        for (int i = 0; i < W; i++) begin
            src = d ? i - s : i + s;
            if (use_rot)                  res[i] = a[(src + W) % W];
            else if (src >= 0 && src < W) res[i] = a[src];
            else                          res[i] = fill;
        end
        return res;
    endfunction

    // One clock cycle: inputs were set after the previous falling edge.
    task automatic tick();
        logic acc, fire, exp_ready;
        #1;
        exp_ready = !rst && (q.size() < L || bus.out_ready);
        check("in_ready", bus.in_ready, exp_ready);
        if (hold_pending) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data", bus.out, held);
        end
        acc  = bus.in_valid && bus.in_ready;
        fire = bus.out_valid && bus.out_ready;
        if (fire) begin
            if (q.size() == 0) check("spurious_valid", bus.out_valid, 1'b0);
            else begin
                check("result", bus.out, q.pop_front());
                emitted++;
            end
        end
        hold_pending = bus.out_valid && !bus.out_ready;
        held = bus.out;
        if (acc) begin
            q.push_back(model(bus.in, int'(bus.shamt), bus.dir, bus.aorl, bus.rot));
            accepted++;
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            hold_pending = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic [W-1:0] a, input int s, input logic d,
                          input logic ar, input logic r);
        bus.in    = a;
        bus.shamt = s[L-1:0];
        bus.dir   = d;
        bus.aorl  = ar;
        bus.rot   = r;
    endtask

    // Single operation into an empty pipe; checks latency and the result.
    task automatic run_one(input logic [W-1:0] a, input int s, input logic d,
                           input logic ar, input logic r, input logic [W-1:0] expv,
                           input string tag);
        int lat;
        set_op(a, s, d, ar, r);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, L);
        check(tag, bus.out, expv);
        tick();
    endtask

    initial begin
        int next, e0, lim;
        logic [W-1:0] v;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_op('0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out", bus.out, '0);
        check("reset_in_ready", bus.in_ready, 1'b1);

        // Directed values from the shifter's defining examples.
        run_one(32'd4567, 4, 1'b1, 1'b0, 1'b0, 32'h00011D70, "shl_4567");
        run_one(32'd4567, 4, 1'b0, 1'b0, 1'b0, 32'h0000011D, "shr_log_4567");
        run_one(32'd4567, 4, 1'b0, 1'b1, 1'b0, 32'h0000011D, "shr_ari_4567");
        run_one(32'hFFFFFFC0, 4, 1'b0, 1'b0, 1'b0, 32'h0FFFFFFC, "shr_log_neg");
        run_one(32'hFFFFFFC0, 4, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, "shr_ari_neg");
        run_one(32'hFFFFFFC0, 4, 1'b1, 1'b0, 1'b0, 32'hFFFFFC00, "shl_neg");
`ifdef SHIFTER_ROTATE_EN
        run_one(32'h80000001, 1, 1'b1, 1'b0, 1'b1, 32'h00000003, "rot_left");
        run_one(32'h80000001, 1, 1'b0, 1'b0, 1'b1, 32'hC0000000, "rot_right");
`else
        run_one(32'h80000001, 1, 1'b1, 1'b0, 1'b1, 32'h00000002, "rot_left_off");
        run_one(32'h80000001, 1, 1'b0, 1'b0, 1'b1, 32'h40000000, "rot_right_off");
`endif
        // Extreme shift amounts.
        run_one(32'h80000000, 31, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, "shr_ari_31");
        run_one(32'h80000000, 31, 1'b0, 1'b0, 1'b0, 32'h00000001, "shr_log_31");
        run_one(32'h00000001, 31, 1'b1, 1'b0, 1'b0, 32'h80000000, "shl_31");
        // shamt = 0 is the identity in every mode.
        for (int m = 0; m < 8; m++) begin
            v = $urandom();
            run_one(v, 0, m[0], m[1], m[2], v, "shamt0_identity");
        end

        // Back-to-back stream of 10 with the consumer stalled in cycles 3-6.
        next = 0;
        e0 = emitted;
        for (int i = 0; i < 100 && emitted - e0 < 10; i++) begin
            bus.out_ready = !(i >= 3 && i <= 6);
            if (next < 10) begin
                bus.in_valid = 1'b1;
                set_op(32'hC3A5_0F01 + next * 32'h0101_1111, next, next % 2 == 1, 1'b1, 1'b0);
            end else begin
                bus.in_valid = 1'b0;
            end
            e0 = e0 + 0;
            lim = accepted;
            tick();
            if (accepted != lim) next++;
        end
        check("stream_emitted", emitted - e0, 10);

        // Random operations under random offer and backpressure.
        next = 0;
        e0 = emitted;
        for (int i = 0; i < 3000 && emitted - e0 < 300; i++) begin
            bus.out_ready = $urandom_range(0, 9) < 7;
            bus.in_valid  = (next < 300) && ($urandom_range(0, 9) < 7);
            set_op($urandom(), int'($urandom_range(0, W - 1)), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            lim = accepted;
            tick();
            if (accepted != lim) next++;
        end
        check("random_emitted", emitted - e0, 300);

        // Reset with three operations in flight; an offer in the reset cycle
        // must not be taken and nothing stale may emerge afterwards.
        bus.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus.in_valid = 1'b1;
            set_op(32'h1234_5678 + j, j + 1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        set_op(32'hDEAD_BEEF, 3, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_out", bus.out, '0);
        for (int j = 0; j < 10; j++) begin
            tick();
            check("midrst_idle", bus.out_valid, 1'b0);
        end
        run_one(32'h0000_00F0, 4, 1'b0, 1'b0, 1'b0, 32'h0000_000F, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
